// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcodes, flag bit positions and
// the per-opcode flag-update mask.
package wisc_pkg;

  localparam int DATA_W = 16;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_t;

  // Which of N/Z/V an opcode is allowed to overwrite; bit positions follow FLAG_*.
  function automatic logic [2:0] flag_mask(opcode_t op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        m[FLAG_N] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_V] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural N/Z/V flag register with per-opcode masked update.
// Define FLAG_BYPASS_EN to forward next-state flags combinationally to the outputs.
module flag_reg
  import wisc_pkg::*;
#(
  parameter int DATA_W = wisc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              update_en,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovfl,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic [2:0] mask;
  logic [2:0] new_flags;
  logic [2:0] flags_out;

  always_comb begin
    mask      = update_en ? flag_mask(opcode_t'(opcode)) : 3'b000;
    new_flags = 3'b000;
    new_flags[FLAG_N] = result[DATA_W-1];
    new_flags[FLAG_Z] = (result == '0);
    new_flags[FLAG_V] = ovfl;
    flags_d = (flags_q & ~mask) | (new_flags & mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 3'b000;
    else        flags_q <= flags_d;
  end

  // flags_d equals flags_q whenever no update is pending, so forwarding it is safe.
`ifdef FLAG_BYPASS_EN
  assign flags_out = flags_d;
`else
  assign flags_out = flags_q;
`endif

  assign flag_n = flags_out[FLAG_N];
  assign flag_z = flags_out[FLAG_Z];
  assign flag_v = flags_out[FLAG_V];

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with stall/flush control; owns the N/Z/V flags via flag_reg.
// Optional FLAG_BYPASS_EN (see flag_reg) forwards pending flag updates combinationally.
module ex_mem_flag_stage #(
  parameter int DATA_W = wisc_pkg::DATA_W,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr_en,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_wr_en,
  output logic [OP_W-1:0]   mem_opcode,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  logic              valid_q,  valid_d;
  logic              wr_en_q,  wr_en_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [REG_AW-1:0] rd_q,     rd_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              flag_update_en;

  // Flush wins over stall; data fields simply hold on a flush.
  always_comb begin
    valid_d  = valid_q;
    wr_en_d  = wr_en_q;
    result_d = result_q;
    rd_d     = rd_q;
    opcode_d = opcode_q;
    if (flush) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      wr_en_d  = ex_wr_en & ex_valid;
      result_d = ex_result;
      rd_d     = ex_rd;
      opcode_d = ex_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      opcode_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_en_q  <= wr_en_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      opcode_q <= opcode_d;
    end
  end

  // rst_n is folded in so a bypassed flag never shows an update that reset discards.
  assign flag_update_en = rst_n & ~flush & ~stall & ex_valid;

  flag_reg #(
    .DATA_W (DATA_W)
  ) u_flag_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .update_en (flag_update_en),
    .opcode    (ex_opcode[3:0]),
    .result    (ex_result),
    .ovfl      (ex_ovfl),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v)
  );

  assign mem_valid  = valid_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_result = result_q;
  assign mem_rd     = rd_q;
  assign mem_opcode = opcode_q;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Table-driven bench for ex_mem_flag_stage plus hand sequences for the bypass path.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [3:0]  ex_rd;
  logic        ex_wr_en;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_wr_en;
  logic [3:0]  mem_opcode;
  logic        flag_n, flag_z, flag_v;

  int checks = 0;
  int errors = 0;

`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ex_mem_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_result  (ex_result),
    .ex_ovfl    (ex_ovfl),
    .ex_rd      (ex_rd),
    .ex_wr_en   (ex_wr_en),
    .stall      (stall),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_wr_en  (mem_wr_en),
    .mem_opcode (mem_opcode),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_v     (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovfl;
    logic [3:0]  rd;
    logic        wr;
    logic        stall;
    logic        flush;
    logic        e_valid;
    logic        e_wr;
    logic        chk_data;
    logic [15:0] e_res;
    logic [3:0]  e_rd;
    logic [3:0]  e_op;
    logic [2:0]  e_nzv;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic r, logic v, logic [3:0] op, logic [15:0] res, logic ov,
                              logic [3:0] rd, logic wr, logic st, logic fl,
                              logic ev, logic ew, logic cd, logic [15:0] eres,
                              logic [3:0] erd, logic [3:0] eop, logic [2:0] enzv);
    vec_t t;
    t.rst_n = r;  t.valid = v;  t.op = op;  t.res = res;  t.ovfl = ov;
    t.rd = rd;    t.wr = wr;    t.stall = st; t.flush = fl;
    t.e_valid = ev; t.e_wr = ew; t.chk_data = cd; t.e_res = eres;
    t.e_rd = erd; t.e_op = eop; t.e_nzv = enzv;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst_n     = t.rst_n;
    ex_valid  = t.valid;
    ex_opcode = t.op;
    ex_result = t.res;
    ex_ovfl   = t.ovfl;
    ex_rd     = t.rd;
    ex_wr_en  = t.wr;
    stall     = t.stall;
    flush     = t.flush;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t t);
    checks++;
    if (mem_valid !== t.e_valid || mem_wr_en !== t.e_wr) begin
      errors++;
      $display("[TB] FAIL vec%0d ctrl: valid/wr got %0b/%0b expected %0b/%0b",
               idx, mem_valid, mem_wr_en, t.e_valid, t.e_wr);
    end
    checks++;
    if ({flag_n, flag_z, flag_v} !== t.e_nzv) begin
      errors++;
      $display("[TB] FAIL vec%0d flags: nzv got %03b expected %03b",
               idx, {flag_n, flag_z, flag_v}, t.e_nzv);
    end
    if (t.chk_data) begin
      checks++;
      if (mem_result !== t.e_res || mem_rd !== t.e_rd || mem_opcode !== t.e_op) begin
        errors++;
        $display("[TB] FAIL vec%0d data: res/rd/op got %h/%0d/%0d expected %h/%0d/%0d",
                 idx, mem_result, mem_rd, mem_opcode, t.e_res, t.e_rd, t.e_op);
      end
    end
  endtask

  initial begin
    //            rst v  op     res       ov rd     wr st fl  ev ew cd eres      erd    eop    nzv
    vecs[0]  = mk(0, 1, 4'h0, 16'h1234, 1, 4'd3, 1, 0, 0,  0, 0, 1, 16'h0000, 4'd0, 4'h0, 3'b000);
    vecs[1]  = mk(0, 1, 4'h0, 16'h1234, 1, 4'd3, 1, 1, 1,  0, 0, 1, 16'h0000, 4'd0, 4'h0, 3'b000);
    vecs[2]  = mk(1, 1, 4'h0, 16'h1234, 0, 4'd3, 1, 0, 0,  1, 1, 1, 16'h1234, 4'd3, 4'h0, 3'b000);
    vecs[3]  = mk(1, 1, 4'h0, 16'h7FFF, 1, 4'd4, 1, 0, 0,  1, 1, 1, 16'h7FFF, 4'd4, 4'h0, 3'b001);
    vecs[4]  = mk(1, 1, 4'h1, 16'h0000, 0, 4'd5, 1, 0, 0,  1, 1, 1, 16'h0000, 4'd5, 4'h1, 3'b010);
    vecs[5]  = mk(1, 1, 4'h0, 16'h8000, 1, 4'd6, 1, 0, 0,  1, 1, 1, 16'h8000, 4'd6, 4'h0, 3'b101);
    vecs[6]  = mk(1, 1, 4'h2, 16'h0000, 0, 4'd7, 1, 0, 0,  1, 1, 1, 16'h0000, 4'd7, 4'h2, 3'b111);
    vecs[7]  = mk(1, 1, 4'h7, 16'h8000, 0, 4'd8, 1, 0, 0,  1, 1, 1, 16'h8000, 4'd8, 4'h7, 3'b111);
    vecs[8]  = mk(1, 1, 4'h4, 16'h0010, 0, 4'd9, 1, 0, 0,  1, 1, 1, 16'h0010, 4'd9, 4'h4, 3'b101);
    vecs[9]  = mk(1, 1, 4'h0, 16'h0005, 0, 4'd1, 1, 0, 0,  1, 1, 1, 16'h0005, 4'd1, 4'h0, 3'b000);
    vecs[10] = mk(1, 1, 4'h1, 16'h0000, 0, 4'd2, 1, 1, 0,  1, 1, 1, 16'h0005, 4'd1, 4'h0, 3'b000);
    vecs[11] = mk(1, 1, 4'h1, 16'h0000, 0, 4'd2, 1, 1, 0,  1, 1, 1, 16'h0005, 4'd1, 4'h0, 3'b000);
    vecs[12] = mk(1, 1, 4'h1, 16'h0000, 0, 4'd2, 1, 1, 0,  1, 1, 1, 16'h0005, 4'd1, 4'h0, 3'b000);
    vecs[13] = mk(1, 1, 4'h1, 16'h0000, 0, 4'd2, 1, 0, 0,  1, 1, 1, 16'h0000, 4'd2, 4'h1, 3'b010);
    vecs[14] = mk(1, 1, 4'h0, 16'h8000, 1, 4'd9, 1, 1, 1,  0, 0, 0, 16'h0000, 4'd0, 4'h0, 3'b010);
    vecs[15] = mk(1, 0, 4'h0, 16'hFFFF, 1, 4'd10, 1, 0, 0, 0, 0, 1, 16'hFFFF, 4'd10, 4'h0, 3'b010);
    vecs[16] = mk(1, 1, 4'h3, 16'h0000, 0, 4'd11, 1, 0, 0, 1, 1, 1, 16'h0000, 4'd11, 4'h3, 3'b010);
    vecs[17] = mk(1, 1, 4'h5, 16'h8000, 1, 4'd12, 1, 0, 0, 1, 1, 1, 16'h8000, 4'd12, 4'h5, 3'b000);
    vecs[18] = mk(1, 1, 4'h6, 16'h0000, 0, 4'd13, 1, 0, 0, 1, 1, 1, 16'h0000, 4'd13, 4'h6, 3'b010);
    vecs[19] = mk(1, 1, 4'h8, 16'hFFFF, 1, 4'd14, 1, 0, 0, 1, 1, 1, 16'hFFFF, 4'd14, 4'h8, 3'b010);
    vecs[20] = mk(1, 1, 4'hF, 16'h0000, 0, 4'd15, 0, 0, 0, 1, 0, 1, 16'h0000, 4'd15, 4'hF, 3'b010);
    vecs[21] = mk(1, 1, 4'h0, 16'hFFFE, 0, 4'd2, 0, 0, 0,  1, 0, 1, 16'hFFFE, 4'd2, 4'h0, 3'b100);
    vecs[22] = mk(1, 1, 4'h1, 16'h0000, 0, 4'd3, 1, 0, 1,  0, 0, 0, 16'h0000, 4'd0, 4'h0, 3'b100);
    vecs[23] = mk(0, 1, 4'h0, 16'h0000, 0, 4'd4, 1, 0, 0,  0, 0, 1, 16'h0000, 4'd0, 4'h0, 3'b000);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Bypass: an ADD with a negative result shows N before its edge only when forwarding.
    applyStimulus(mk(1, 1, 4'h0, 16'hFFFE, 0, 4'd5, 1, 0, 0, 0, 0, 0, 16'h0, 4'd0, 4'h0, 3'b000));
    #2;
    checkBit("bypass_n_pre_edge", flag_n, BYPASS);
    checkBit("bypass_z_pre_edge", flag_z, 1'b0);
    @(posedge clk);
    #1;
    checkBit("bypass_n_post_edge", flag_n, 1'b1);

    // A stalled flag-setting instruction is not pending, so nothing is forwarded.
    applyStimulus(mk(1, 1, 4'h1, 16'h0000, 0, 4'd6, 1, 1, 0, 0, 0, 0, 16'h0, 4'd0, 4'h0, 3'b000));
    #2;
    checkBit("stall_no_bypass_z", flag_z, 1'b0);
    checkBit("stall_no_bypass_n", flag_n, 1'b1);
    @(posedge clk);
    #1;
    checkBit("stall_hold_z", flag_z, 1'b0);
    stall = 1'b0;
    @(posedge clk);
    #1;
    checkBit("release_z", flag_z, 1'b1);
    checkBit("release_n", flag_n, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
